// File: rtl/softbody_fx_if.sv
// Control, configuration and frame-output bundle for the soft-body display engine.
interface softbody_fx_if #(
  parameter int unsigned N_PERIPH = 3,
  parameter int unsigned GRID     = 16,
  parameter int unsigned W        = 16
);
  logic                      step;
  logic                      btn_left;
  logic                      btn_right;
  logic                      btn_up;
  logic                      btn_down;
  logic [N_PERIPH*2*W-1:0]   rest_cfg;
  logic [GRID*GRID-1:0]      matrix;
  logic                      frame_valid;
  logic                      busy;
  logic                      overrun;

  modport master (
    output step, btn_left, btn_right, btn_up, btn_down, rest_cfg,
    input  matrix, frame_valid, busy, overrun
  );

  modport slave (
    input  step, btn_left, btn_right, btn_up, btn_down, rest_cfg,
    output matrix, frame_valid, busy, overrun
  );
endinterface

// File: rtl/softbody_fx.sv
// Time-multiplexed fixed-point soft-body engine: one center particle, N spring-tethered
// peripherals, rasterised one row per cycle into a GRID x GRID frame buffer.
module softbody_fx #(
  parameter int unsigned N_PERIPH = 3,
  parameter int unsigned GRID     = 16,
  parameter int unsigned W        = 16,
  parameter int unsigned FRAC     = 8,
  parameter int unsigned K_SH     = 1,
  parameter int unsigned D_SH     = 2,
  parameter int unsigned DT_SH    = 2,
  parameter int unsigned FORCE_Q  = 512
) (
  input logic          clk,
  input logic          reset,
  softbody_fx_if.slave bus
);
  localparam int unsigned WX = W + 2;
  localparam int unsigned IW = (N_PERIPH > 1) ? $clog2(N_PERIPH) : 1;
  localparam int unsigned RW = $clog2(GRID);

  typedef logic signed [W-1:0]  sw_t;
  typedef logic signed [WX-1:0] sx_t;
  typedef enum logic [2:0] {IDLE, CENTER, PERIPH, RENDER, LOAD} state_t;

  localparam sx_t SMAX = sx_t'({1'b0, {(W-1){1'b1}}});
  localparam sx_t SMIN = -SMAX - sx_t'(1);
  localparam sw_t PMAX = sw_t'((GRID << FRAC) - 1);
  localparam sw_t C0   = sw_t'((GRID / 2) << FRAC);
  localparam sw_t FQ   = sw_t'(FORCE_Q);

  state_t state_q, state_d;
  logic [IW-1:0]        idx;
  logic [RW-1:0]        row;
  sw_t                  pcx, pcy, vcx, vcy, fx, fy;
  sw_t                  px [N_PERIPH];
  sw_t                  py [N_PERIPH];
  sw_t                  vx [N_PERIPH];
  sw_t                  vy [N_PERIPH];
  logic [GRID*GRID-1:0] shadow, matrix_q;
  logic                 frame_valid_q, busy_q, overrun_q;

  function automatic sw_t sat(input sx_t x);
    sw_t r;
    r = sw_t'(x);
    if (x > SMAX)      r = sw_t'(SMAX);
    else if (x < SMIN) r = sw_t'(SMIN);
    return r;
  endfunction

  // Inelastic wall: clamp into the grid and reflect half the velocity.
  function automatic void wall(input sw_t p, input sw_t v, output sw_t po, output sw_t vo);
    po = p;
    vo = v;
    if (p < sw_t'(0)) begin
      po = '0;
      vo = sw_t'(-(v >>> 1));
    end else if (p > PMAX) begin
      po = PMAX;
      vo = sw_t'(-(v >>> 1));
    end
  endfunction

  function automatic void center_axis(input sw_t p, input sw_t v, input sw_t f,
                                      output sw_t po, output sw_t vo);
    sw_t v1, v2, p1;
    v1 = sat(sx_t'(v) + sx_t'(f >>> DT_SH));
    v2 = sat(sx_t'(v1) - sx_t'(v1 >>> D_SH));
    p1 = sat(sx_t'(p) + sx_t'(v2 >>> DT_SH));
    wall(p1, v2, po, vo);
  endfunction

  function automatic void periph_axis(input sw_t pc, input sw_t rest, input sw_t p, input sw_t v,
                                      output sw_t po, output sw_t vo);
    sw_t e, a, v1, p1;
    e  = sat(sx_t'(pc) + sx_t'(rest) - sx_t'(p));
    a  = sat(sx_t'(e >>> K_SH) - sx_t'(v >>> D_SH));
    v1 = sat(sx_t'(v) + sx_t'(a >>> DT_SH));
    p1 = sat(sx_t'(p) + sx_t'(v1 >>> DT_SH));
    wall(p1, v1, po, vo);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.step) state_d = CENTER;
      CENTER:  state_d = PERIPH;
      PERIPH:  if (idx == IW'(N_PERIPH - 1)) state_d = RENDER;
      RENDER:  if (row == RW'(GRID - 1)) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Particle updates for the current cycle; peripherals read rest_cfg live.
  sw_t ncx, ncy, nvcx, nvcy, rest_dx, rest_dy, npx, npy, nvx, nvy;
  always_comb begin
    rest_dx = sw_t'(bus.rest_cfg[int'(idx)*2*W +: W]);
    rest_dy = sw_t'(bus.rest_cfg[int'(idx)*2*W + W +: W]);
    center_axis(pcx, vcx, fx, ncx, nvcx);
    center_axis(pcy, vcy, fy, ncy, nvcy);
    periph_axis(pcx, rest_dx, px[idx], vx[idx], npx, nvx);
    periph_axis(pcy, rest_dy, py[idx], vy[idx], npy, nvy);
  end

  // Row rasteriser: center plus-shape clipped at the edges, peripherals as single cells.
  logic [GRID-1:0] row_bits;
  int cx, cy, r;
  always_comb begin
    row_bits = '0;
    cx = int'(pcx >>> FRAC);
    cy = int'(pcy >>> FRAC);
    r  = int'(row);
    for (int x = 0; x < int'(GRID); x++) begin
      if ((cy == r && x >= cx - 1 && x <= cx + 1) || ((cy == r - 1 || cy == r + 1) && x == cx))
        row_bits[RW'(x)] = 1'b1;
      for (int i = 0; i < int'(N_PERIPH); i++)
        if (int'(px[IW'(i)] >>> FRAC) == x && int'(py[IW'(i)] >>> FRAC) == r)
          row_bits[RW'(x)] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx           <= '0;
      row           <= '0;
      pcx           <= C0;
      pcy           <= C0;
      vcx           <= '0;
      vcy           <= '0;
      fx            <= '0;
      fy            <= '0;
      shadow        <= '0;
      matrix_q      <= '0;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      for (int i = 0; i < int'(N_PERIPH); i++) begin
        px[IW'(i)] <= sat(sx_t'(C0) + sx_t'(sw_t'(bus.rest_cfg[i*2*W +: W])));
        py[IW'(i)] <= sat(sx_t'(C0) + sx_t'(sw_t'(bus.rest_cfg[i*2*W + W +: W])));
        vx[IW'(i)] <= '0;
        vy[IW'(i)] <= '0;
      end
    end else begin
      frame_valid_q <= 1'b0;
      busy_q        <= (state_d != IDLE);
      if (bus.step && state_q != IDLE) overrun_q <= 1'b1;
      case (state_q)
        IDLE: if (bus.step) begin
          idx <= '0;
          row <= '0;
          fx  <= '0;
          fy  <= '0;
          if (bus.btn_left)       fx <= -FQ;
          else if (bus.btn_right) fx <= FQ;
          else if (bus.btn_up)    fy <= FQ;
          else if (bus.btn_down)  fy <= -FQ;
        end
        CENTER: begin
          pcx <= ncx;
          pcy <= ncy;
          vcx <= nvcx;
          vcy <= nvcy;
        end
        PERIPH: begin
          px[idx] <= npx;
          py[idx] <= npy;
          vx[idx] <= nvx;
          vy[idx] <= nvy;
          idx     <= IW'(idx + IW'(1));
        end
        RENDER: begin
          shadow[int'(row)*GRID +: GRID] <= row_bits;
          row <= RW'(row + RW'(1));
        end
        LOAD: begin
          matrix_q      <= shadow;
          frame_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.matrix      = matrix_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.busy        = busy_q;
  assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_softbody_fx.sv
// Scoreboard bench for softbody_fx: a plain-integer particle model predicts each frame
// and its arrival cycle; a monitor checks every frame_valid against the queue.
module tb_softbody_fx;
  localparam int N = 3, G = 16, W = 16, FRAC = 8;
  localparam int K_SH = 1, D_SH = 2, DT_SH = 2, FQ = 512;
  localparam int PMAX = (G << FRAC) - 1;
  localparam int LAT = 21;

  typedef struct {
    logic [G*G-1:0] m;
    int             cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0, n_bad = 0, frames = 0, cyc = 0;
  exp_t q[$];

  int mcx, mcy, mvx, mvy;
  int mpx[N], mpy[N], mvpx[N], mvpy[N];
  int rdx[N], rdy[N];

  softbody_fx_if #(.N_PERIPH(N), .GRID(G), .W(W)) bus ();

  softbody_fx #(
    .N_PERIPH(N), .GRID(G), .W(W), .FRAC(FRAC), .K_SH(K_SH), .D_SH(D_SH),
    .DT_SH(DT_SH), .FORCE_Q(FQ)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [G*G-1:0] act, input logic [G*G-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int sat(input int x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic void bounce(inout int p, inout int v);
    if (p < 0) begin
      p = 0;
      v = -(v >>> 1);
    end else if (p > PMAX) begin
      p = PMAX;
      v = -(v >>> 1);
    end
  endfunction

  function automatic void push_center(inout int p, inout int v, input int f);
    v = sat(v + (f >>> DT_SH));
    v = sat(v - (v >>> D_SH));
    p = sat(p + (v >>> DT_SH));
    bounce(p, v);
  endfunction

  function automatic void spring(input int pc, input int rest, inout int p, inout int v);
    int e, a;
    e = sat(pc + rest - p);
    a = sat((e >>> K_SH) - (v >>> D_SH));
    v = sat(v + (a >>> DT_SH));
    p = sat(p + (v >>> DT_SH));
    bounce(p, v);
  endfunction

  function automatic void model_reset();
    mcx = (G / 2) << FRAC;
    mcy = (G / 2) << FRAC;
    mvx = 0;
    mvy = 0;
    for (int i = 0; i < N; i++) begin
      mpx[i] = sat(mcx + rdx[i]);
      mpy[i] = sat(mcy + rdy[i]);
      mvpx[i] = 0;
      mvpy[i] = 0;
    end
  endfunction

  function automatic void model_step(input int f_x, input int f_y);
    push_center(mcx, mvx, f_x);
    push_center(mcy, mvy, f_y);
    for (int i = 0; i < N; i++) begin
      spring(mcx, rdx[i], mpx[i], mvpx[i]);
      spring(mcy, rdy[i], mpy[i], mvpy[i]);
    end
  endfunction

  function automatic void light(inout logic [G*G-1:0] m, input int x, input int y);
    if (x >= 0 && x < G && y >= 0 && y < G) m[y*G + x] = 1'b1;
  endfunction

  function automatic logic [G*G-1:0] model_frame();
    logic [G*G-1:0] m;
    int x, y;
    m = '0;
    x = mcx >>> FRAC;
    y = mcy >>> FRAC;
    light(m, x, y);
    light(m, x - 1, y);
    light(m, x + 1, y);
    light(m, x, y - 1);
    light(m, x, y + 1);
    for (int i = 0; i < N; i++) light(m, mpx[i] >>> FRAC, mpy[i] >>> FRAC);
    return m;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.frame_valid === 1'b1) begin
        frames++;
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_frame: got frame_valid at cycle %0d expected none", cyc);
        end else begin
          e = q.pop_front();
          chk_vec("frame_matrix", bus.matrix, e.m);
          chk_int("frame_latency", cyc, e.cyc);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic apply_rest();
    for (int i = 0; i < N; i++) begin
      bus.rest_cfg[i*2*W +: W]     = W'(rdx[i]);
      bus.rest_cfg[i*2*W + W +: W] = W'(rdy[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    apply_rest();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Called on a negedge; issues a one-cycle step and predicts its frame.
  task automatic do_step(input logic l, input logic r, input logic u, input logic d);
    int f_x, f_y;
    exp_t e;
    bus.btn_left = l;
    bus.btn_right = r;
    bus.btn_up = u;
    bus.btn_down = d;
    bus.step = 1'b1;
    f_x = 0;
    f_y = 0;
    if (l)      f_x = -FQ;
    else if (r) f_x = FQ;
    else if (u) f_y = FQ;
    else if (d) f_y = -FQ;
    model_step(f_x, f_y);
    e.m = model_frame();
    e.cyc = cyc + LAT + 1;
    q.push_back(e);
    @(negedge clk);
    bus.step = 1'b0;
    bus.btn_left = 1'b0;
    bus.btn_right = 1'b0;
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (bus.frame_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL frame_timeout: got no frame_valid within 40 cycles expected one");
    end
  endtask

  initial begin
    int f0;
    bus.step = 1'b0;
    bus.btn_left = 1'b0;
    bus.btn_right = 1'b0;
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    rdx[0] = 0;    rdy[0] = -512;
    rdx[1] = -512; rdy[1] = 512;
    rdx[2] = 512;  rdy[2] = 512;
    apply_rest();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();

    chk_vec("reset_matrix", bus.matrix, '0);
    chk_int("reset_busy", int'(bus.busy), 0);
    chk_int("reset_frame_valid", int'(bus.frame_valid), 0);
    chk_int("reset_overrun", int'(bus.overrun), 0);

    // Equilibrium frame: plus at (8,8) and peripherals at (8,6), (6,10), (10,10).
    do_step(0, 0, 0, 0);
    chk_int("busy_during_step", int'(bus.busy), 1);
    wait_frame();
    chk_int("busy_in_frame_cycle", int'(bus.busy), 0);

    // One rightward push from equilibrium.
    do_step(0, 1, 0, 0);
    wait_frame();
    chk_int("right_center_vx", int'(dut.vcx), mvx);
    chk_int("right_center_px", int'(dut.pcx), mcx);
    chk_int("right_center_py", int'(dut.pcy), mcy);
    chk_int("right_p0_vx", int'(dut.vx[0]), mvpx[0]);
    chk_int("right_p0_px", int'(dut.px[0]), mpx[0]);
    chk_int("right_p0_py", int'(dut.py[0]), mpy[0]);

    // Left wall: 200 back-to-back steps, each issued in the previous frame_valid cycle.
    do_reset();
    do_step(1, 0, 0, 0);
    repeat (199) begin
      wait_frame();
      do_step(1, 0, 0, 0);
    end
    wait_frame();
    chk_int("wall_center_column", int'(dut.pcx >>> FRAC), 0);

    // Randomised buttons, gaps and live rest offsets.
    for (int i = 0; i < N; i++) begin
      rdx[i] = int'($urandom_range(0, 4608)) - 2304;
      rdy[i] = int'($urandom_range(0, 4608)) - 2304;
    end
    do_reset();
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 2) != 0) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if ($urandom_range(0, 3) == 0) begin
          rdx[s % N] = int'($urandom_range(0, 4608)) - 2304;
          rdy[s % N] = int'($urandom_range(0, 4608)) - 2304;
          apply_rest();
        end
      end
      do_step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_frame();
    end

    // Second step 5 cycles after the first is ignored and flags overrun.
    @(negedge clk);
    f0 = frames;
    do_step(0, 0, 1, 0);
    repeat (4) @(negedge clk);
    chk_int("overrun_before", int'(bus.overrun), 0);
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    chk_int("overrun_set", int'(bus.overrun), 1);
    wait_frame();
    repeat (30) @(negedge clk);
    chk_int("overrun_frame_count", frames - f0, 1);
    chk_int("overrun_sticky", int'(bus.overrun), 1);

    // Reset while the peripherals are being updated.
    f0 = frames;
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_int("periph_busy", int'(bus.busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk_int("abort_busy", int'(bus.busy), 0);
    chk_vec("abort_matrix", bus.matrix, '0);
    chk_int("abort_overrun", int'(bus.overrun), 0);
    chk_int("abort_center_px", int'(dut.pcx), mcx);
    chk_int("abort_center_vx", int'(dut.vcx), mvx);
    chk_int("abort_p1_px", int'(dut.px[1]), mpx[1]);
    chk_int("abort_p2_py", int'(dut.py[2]), mpy[2]);
    repeat (30) @(negedge clk);
    chk_int("abort_no_frame", frames - f0, 0);
    do_step(0, 0, 0, 1);
    wait_frame();

    repeat (3) @(negedge clk);
    chk_int("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
